keypad_number_entry: RTL
========================

// Module: keypad_number_entry
// PURPOSE
//  Input-side counterpart of the 4-digit seven-segment display path. Scans a 4x4 matrix
//  keypad, debounces it and builds a decimal number of up to 4 digits. 'D' clears the
//  entry and '*' deletes the last digit. '#' commits the value on num with a one-cycle
//  num_valid pulse. The live entry value feeds the display driver so the user sees typing.
// PARAMETERS
//  SCAN_DIV_W      18  column slot length = 2**SCAN_DIV_W clk cycles (~2.6 ms @100 MHz)
//  DEBOUNCE_SCANS  4   consecutive identical full scans needed to accept a press/release
//  NUM_W           14  width of entry/num (holds 0..9999)
// PORTS
//  clk          in   1      system clock, all flops rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  row_in       in   4      keypad rows, active-low (external pull-ups), asynchronous
//  col_out      out  4      column drive, active-low one-hot
//  key_code     out  4      code of last accepted key (0-9 digits, A-D=0xA-0xD, *=0xE, #=0xF)
//  key_strobe   out  1      1-cycle pulse when a key press is accepted
//  entry        out  NUM_W  live value being typed (binary)
//  digit_count  out  3      digits in entry, 0..4
//  num          out  NUM_W  last committed value (binary)
//  num_valid    out  1      1-cycle pulse when num is updated
// BEHAVIOUR
//  Reset (async): col_out=4'b1110; key_code=0; key_strobe=0; entry=0; digit_count=0;
//   num=0; num_valid=0; FSM=IDLE; all counters 0. Deassertion is taken synchronously.
//  Keymap rows r0..r3 x cols c0..c3: [1 2 3 A][4 5 6 B][7 8 9 C][* 0 # D].
//  Scan: col_out rotates 1110->1101->1011->0111->1110, one slot per 2**SCAN_DIV_W clks.
//   row_in passes through a 2-flop synchroniser. It is sampled on the last clk of each slot.
//   A full scan is 4 slots. Scan result = the key code if exactly one key is down, else NONE.
//   Multiple keys down (ghosting) count as NONE.
//  Debounce FSM, evaluated once per completed scan:
//   IDLE:     result!=NONE -> DEBOUNCE, cand=result, cnt=1.
//   DEBOUNCE: result==cand -> cnt++; when cnt==DEBOUNCE_SCANS -> HELD, accept cand.
//             result!=cand -> IDLE (a new key restarts from IDLE on the next scan).
//   HELD:     result==NONE for DEBOUNCE_SCANS consecutive scans -> IDLE; any key resets
//             that count. No auto-repeat; a second key pressed while held is ignored.
//  Accept: key_code<=cand and key_strobe=1 on the same edge that updates entry/count.
//   digit d, count<4 : entry<=entry*10+d, count++.
//   digit d, count==4: ignored (entry stays, no overflow).
//   '*': count>0 -> entry<=entry/10, count--; count==0 -> no change.
//   'D': entry<=0, count<=0.
//   '#': num<=entry, num_valid=1, entry<=0, count<=0. An empty entry commits 0.
//   A/B/C: strobe only, entry unchanged.
//  Arithmetic is unsigned NUM_W-bit. entry never exceeds 9999 by construction.
//  At most one accept per scan, so key events never coincide. key_strobe and num_valid
//   are both high on a '#' accept.
//  Reset mid-operation: abandons any debounce/held state. A key still held after reset
//   needs a full fresh DEBOUNCE_SCANS before it is accepted.
// STRUCTURE
//  Package keypad_pkg holds:
//   - key code localparams: KEY_STAR=4'hE, KEY_HASH=4'hF, KEY_CLR=4'hD, KEY_NONE;
//   - the 4x4 keymap table;
//   - FSM state encoding (IDLE/DEBOUNCE/HELD);
//   - COL_INIT=4'b1110.
//  Sub-module keypad_scanner contains the column rotation, synchroniser, scan decode and
//   debounce FSM, and outputs key_code/key_strobe.
//  The top level adds the entry accumulator and the commit register.
// TESTING (behavioural keypad model ties row to col when a key is down; SCAN_DIV_W=2,
//  DEBOUNCE_SCANS=4, so one scan = 16 clk)
//  1 Reset: rst_n=0 -> col_out=1110, entry/num/count=0, strobes 0, held during clk toggling.
//  2 Keys 1,2,3,4,#, each held 8 scans then released 8 scans -> strobes with codes
//    1,2,3,4,F; entry 1,12,123,1234; then num=1234, one num_valid pulse, entry=0, count=0.
//  3 Keys 9,9,9,9,5,# -> entry stays 9999 after the 5th digit; num=9999, count 4 before #.
//  4 Keys 5,6,*,7 -> entry 57, count 2; then D -> entry 0; then * -> no change, strobe only.
//  5 Key 8 chattering every 8 clk for 5 scans, then held 100 scans -> exactly one strobe.
//    Keys 1 and 5 held together -> no strobe.
//  6 rst_n pulsed low during DEBOUNCE of key 3 with the key still held -> no strobe for
//    DEBOUNCE_SCANS full scans after release of reset, then exactly one strobe with code 3.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared key codes, keymap table, debounce FSM encoding and column reset pattern
// for the keypad number-entry path.
package keypad_pkg;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;
  localparam logic [3:0] KEY_CLR  = 4'hD;
  // Every 4-bit value is a real key, so "no key" needs a fifth bit
  localparam logic [4:0] KEY_NONE = 5'h10;

  typedef logic [4:0] scan_code_t;

  // Indexed by {row, col}: [1 2 3 A][4 5 6 B][7 8 9 C][* 0 # D]
  localparam logic [15:0][3:0] KEYMAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

  localparam logic [3:0] COL_INIT = 4'b1110;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner, row synchroniser, single-key scan decode and debounce FSM.
// Produces one accept per debounced press, both as a combinational pulse and registered.
import keypad_pkg::*;

module keypad_scanner #(
  parameter int SCAN_DIV_W     = 18,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_strobe,
  output logic       accept,
  output logic [3:0] accept_code
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS);

  logic [SCAN_DIV_W-1:0] r_div;
  logic [3:0]            r_col;
  logic [1:0]            r_col_idx;
  logic [3:0]            r_row_meta;
  logic [3:0]            r_row_sync;
  logic [1:0]            r_hits;
  logic [3:0]            r_hit_code;
  logic [1:0]            r_state;
  logic [3:0]            r_cand;
  logic [CNT_W-1:0]      r_cnt;
  logic [3:0]            r_key_code;
  logic                  r_key_strobe;

  logic                  w_slot_end;
  logic                  w_scan_done;
  logic [3:0]            w_row_code [4];
  logic [2:0]            w_col_hits;
  logic [3:0]            w_col_code;
  logic [2:0]            w_sum;
  logic [1:0]            w_hits_sat;
  logic [3:0]            w_code_acc;
  scan_code_t            w_result;
  logic [1:0]            w_state_next;
  logic [3:0]            w_cand_next;
  logic [CNT_W-1:0]      w_cnt_next;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_accept;

  assign w_slot_end  = &r_div;
  assign w_scan_done = w_slot_end && (r_col_idx == 2'd3);

  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    localparam logic [1:0] ROW = 2'(gi);
    assign w_row_code[gi] = KEYMAP[{ROW, r_col_idx}];
  end

  always_comb begin
    w_col_hits = 3'd0;
    w_col_code = 4'd0;
    for (int r = 0; r < 4; r++) begin
      if (!r_row_sync[r]) begin
        w_col_hits = w_col_hits + 3'd1;
        w_col_code = w_row_code[r];
      end
    end
  end

  // Hit count saturates at 2: all we need to know is "none", "one" or "ghosted"
  assign w_sum      = {1'b0, r_hits} + w_col_hits;
  assign w_hits_sat = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
  assign w_code_acc = (w_col_hits != 3'd0) ? w_col_code : r_hit_code;
  assign w_result   = (w_hits_sat == 2'd1) ? {1'b0, w_code_acc} : KEY_NONE;
  assign w_cnt_inc  = r_cnt + CNT_ONE;

  always_comb begin
    w_state_next = r_state;
    w_cand_next  = r_cand;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    if (w_scan_done) begin
      case (r_state)
        ST_IDLE: begin
          if (w_result != KEY_NONE) begin
            w_cand_next = w_result[3:0];
            if (CNT_ONE == CNT_LAST) begin
              w_state_next = ST_HELD;
              w_cnt_next   = '0;
              w_accept     = 1'b1;
            end else begin
              w_state_next = ST_DEBOUNCE;
              w_cnt_next   = CNT_ONE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (w_result == {1'b0, r_cand}) begin
            if (w_cnt_inc == CNT_LAST) begin
              w_state_next = ST_HELD;
              w_cnt_next   = '0;
              w_accept     = 1'b1;
            end else begin
              w_cnt_next = w_cnt_inc;
            end
          end else begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
          end
        end
        ST_HELD: begin
          // Any key activity restarts the release count; no auto-repeat
          if (w_result == KEY_NONE) begin
            if (w_cnt_inc == CNT_LAST) begin
              w_state_next = ST_IDLE;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next = w_cnt_inc;
            end
          end else begin
            w_cnt_next = '0;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div        <= '0;
      r_col        <= COL_INIT;
      r_col_idx    <= 2'd0;
      r_row_meta   <= 4'hF;
      r_row_sync   <= 4'hF;
      r_hits       <= 2'd0;
      r_hit_code   <= 4'd0;
      r_state      <= ST_IDLE;
      r_cand       <= 4'd0;
      r_cnt        <= '0;
      r_key_code   <= 4'd0;
      r_key_strobe <= 1'b0;
    end else begin
      r_div        <= r_div + 1'b1;
      r_row_meta   <= row_in;
      r_row_sync   <= r_row_meta;
      r_state      <= w_state_next;
      r_cand       <= w_cand_next;
      r_cnt        <= w_cnt_next;
      r_key_strobe <= w_accept;
      if (w_accept) begin
        r_key_code <= w_cand_next;
      end
      if (w_slot_end) begin
        r_col     <= {r_col[2:0], r_col[3]};
        r_col_idx <= r_col_idx + 2'd1;
        if (w_scan_done) begin
          r_hits     <= 2'd0;
          r_hit_code <= 4'd0;
        end else begin
          r_hits     <= w_hits_sat;
          r_hit_code <= w_code_acc;
        end
      end
    end
  end

  assign col_out     = r_col;
  assign key_code    = r_key_code;
  assign key_strobe  = r_key_strobe;
  assign accept      = w_accept;
  assign accept_code = w_cand_next;

endmodule

// File: rtl/keypad_number_entry.sv
// Keypad number entry: debounced key stream drives a 4-digit decimal accumulator,
// with clear, backspace and commit keys.
import keypad_pkg::*;

module keypad_number_entry #(
  parameter int SCAN_DIV_W     = 18,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int NUM_W          = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       row_in,
  output logic [3:0]       col_out,
  output logic [3:0]       key_code,
  output logic             key_strobe,
  output logic [NUM_W-1:0] entry,
  output logic [2:0]       digit_count,
  output logic [NUM_W-1:0] num,
  output logic             num_valid
);

  logic             r_rst_meta;
  logic             r_rst_n;
  logic [NUM_W-1:0] r_entry;
  logic [2:0]       r_count;
  logic [NUM_W-1:0] r_num;
  logic             r_num_valid;

  logic             w_accept;
  logic [3:0]       w_code;

  // Reset asserts immediately but releases two clocks later, on a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_n    <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_n    <= r_rst_meta;
    end
  end

  keypad_scanner #(
    .SCAN_DIV_W     (SCAN_DIV_W),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_scanner (
    .clk         (clk),
    .rst_n       (r_rst_n),
    .row_in      (row_in),
    .col_out     (col_out),
    .key_code    (key_code),
    .key_strobe  (key_strobe),
    .accept      (w_accept),
    .accept_code (w_code)
  );

  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_entry     <= '0;
      r_count     <= 3'd0;
      r_num       <= '0;
      r_num_valid <= 1'b0;
    end else begin
      r_num_valid <= 1'b0;
      if (w_accept) begin
        if (is_digit(w_code)) begin
          if (r_count < 3'd4) begin
            r_entry <= r_entry * NUM_W'(10) + NUM_W'(w_code);
            r_count <= r_count + 3'd1;
          end
        end else begin
          case (w_code)
            KEY_STAR: begin
              if (r_count != 3'd0) begin
                r_entry <= r_entry / NUM_W'(10);
                r_count <= r_count - 3'd1;
              end
            end
            KEY_CLR: begin
              r_entry <= '0;
              r_count <= 3'd0;
            end
            KEY_HASH: begin
              r_num       <= r_entry;
              r_num_valid <= 1'b1;
              r_entry     <= '0;
              r_count     <= 3'd0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign entry       = r_entry;
  assign digit_count = r_count;
  assign num         = r_num;
  assign num_valid   = r_num_valid;

endmodule
